// File: rtl/hazard_scoreboard_if.sv
// Decode <-> hazard unit signal bundle: decode drives the instruction fields,
// the scoreboard returns stall/forward decisions and status counters.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 2,
  parameter int SEL_W      = 2
);
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] src1_addr;
  logic                  src1_used;
  logic [REG_ADDR_W-1:0] src2_addr;
  logic                  src2_used;
  logic [REG_ADDR_W-1:0] dst_addr;
  logic                  dst_we;
  logic [LAT_W-1:0]      dst_lat;
  logic                  flush;
  logic                  stall;
  logic [SEL_W-1:0]      fwd_sel1;
  logic [SEL_W-1:0]      fwd_sel2;
  logic [SEL_W-1:0]      inflight_cnt;
  logic [15:0]           stall_count;

  modport master (
    output issue_valid, src1_addr, src1_used, src2_addr, src2_used,
           dst_addr, dst_we, dst_lat, flush,
    input  stall, fwd_sel1, fwd_sel2, inflight_cnt, stall_count
  );

  modport slave (
    input  issue_valid, src1_addr, src1_used, src2_addr, src2_used,
           dst_addr, dst_we, dst_lat, flush,
    output stall, fwd_sel1, fwd_sel2, inflight_cnt, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit tracking in-flight writes over PIPE_DEPTH post-decode stages.
// Macro HAZARD_FWD_EN enables the bypass network; when undefined any match stalls until retire.
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int PIPE_DEPTH   = 3,
  parameter int LAT_W        = 2,
  parameter int SEL_W        = 2,
  parameter int FLUSH_STAGES = 1,
  parameter int ZERO_REG     = 1
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave hz
);

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [REG_ADDR_W-1:0] dest_q [PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] dest_d [PIPE_DEPTH];
  logic [SEL_W-1:0]      inflight_q, inflight_d;
  logic [15:0]           stall_count_q, stall_count_d;

  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [1:0]            src_used;
  logic [1:0]            src_haz;
  logic [SEL_W-1:0]      src_sel [2];
  logic                  stall;
  logic                  issue;

  assign src_addr[0] = hz.src1_addr;
  assign src_addr[1] = hz.src2_addr;
  assign src_used    = {hz.src2_used, hz.src1_used};

`ifdef HAZARD_FWD_EN
  logic [LAT_W-1:0] rdy_q [PIPE_DEPTH];
  logic [LAT_W-1:0] rdy_d [PIPE_DEPTH];
`else
  logic unused_lat;
  assign unused_lat = ^hz.dst_lat;
`endif

  // Scan oldest to youngest so the youngest matching stage overwrites the result.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_haz[s] = 1'b0;
      src_sel[s] = '0;
      if (src_used[s] && !((ZERO_REG != 0) && (src_addr[s] == '0))) begin
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
          if (valid_q[k] && (dest_q[k] == src_addr[s])) begin
`ifdef HAZARD_FWD_EN
            src_haz[s] = (rdy_q[k] != '0);
            src_sel[s] = SEL_W'(k + 1);
`else
            src_haz[s] = 1'b1;
`endif
          end
        end
      end
    end
  end

  assign stall = hz.issue_valid & (|src_haz) & ~hz.flush;
  assign issue = hz.issue_valid & ~stall & ~hz.flush;

  always_comb begin
    valid_d[0] = issue & hz.dst_we & ((hz.dst_addr != '0) | (ZERO_REG == 0));
    dest_d[0]  = hz.dst_addr;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      dest_d[k]  = dest_q[k-1];
    end
    // Flush kills whatever would land in the youngest stages, new issue included.
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (hz.flush && (k < FLUSH_STAGES)) valid_d[k] = 1'b0;
    end
    inflight_d = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      inflight_d = inflight_d + SEL_W'(valid_d[k]);
    end
    stall_count_d = (stall && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1
                                                           : stall_count_q;
  end

`ifdef HAZARD_FWD_EN
  always_comb begin
    if (hz.dst_lat == '0)                  rdy_d[0] = '0;
    else if (int'(hz.dst_lat) > PIPE_DEPTH) rdy_d[0] = LAT_W'(PIPE_DEPTH - 1);
    else                                    rdy_d[0] = hz.dst_lat - LAT_W'(1);
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      rdy_d[k] = (rdy_q[k-1] == '0) ? '0 : rdy_q[k-1] - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) rdy_q[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE_DEPTH; k++) rdy_q[k] <= rdy_d[k];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      inflight_q    <= '0;
      stall_count_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) dest_q[k] <= '0;
    end else begin
      valid_q       <= valid_d;
      inflight_q    <= inflight_d;
      stall_count_q <= stall_count_d;
      for (int k = 0; k < PIPE_DEPTH; k++) dest_q[k] <= dest_d[k];
    end
  end

  assign hz.stall        = stall;
  assign hz.fwd_sel1     = src_sel[0];
  assign hz.fwd_sel2     = src_sel[1];
  assign hz.inflight_cnt = inflight_q;
  assign hz.stall_count  = stall_count_q;

endmodule
